lcd_nibble_tx: RTL
==================

LCD_NIBBLE_TX -- requirements
Module: lcd_nibble_tx

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, 50 MHz; reset  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have start  in  1  one-cycle request from the instruction sequencer ("next instruction").
REQ-003 SHALL have db_in  in  10  instruction word: bit9 = RS, bit8 = RW (ignored), bits7:0 = data/command.
REQ-004 SHALL have done  out  1  one-cycle pulse when the accepted instruction's 40 us execution wait ends.
REQ-005 SHALL have ready  out  1  power-on init complete; busy  out  1  high from capture until done.
REQ-006 SHALL have lcd_e, lcd_rs, lcd_rw  out  1 each; lcd_d  out  4  LCD upper data lines DB7:DB4; sf_ce0  out  1  StrataFlash disable.

Function
REQ-007 SHALL execute power-on init once after reset: wait 750000 cycles (15 ms); nibble 0x3; wait 205000 (4.1 ms); 0x3; wait 5000 (100 us); 0x3; wait 2000 (40 us); 0x2; wait 2000; then ready=1.
REQ-008 Every nibble write SHALL be: lcd_d/lcd_rs valid 2 cycles (setup), lcd_e high 12 cycles, lcd_e low with data held 1 cycle (hold).
REQ-009 Init nibbles SHALL drive lcd_rs=0.
REQ-010 start SHALL be sampled only when ready=1 and busy=0; otherwise ignored, not queued.
REQ-011 db_in SHALL be captured on the clock edge one cycle after the edge that samples start (the sequencer updates db one cycle after asserting start); busy SHALL go high on the sampling edge.
REQ-012 After capture: high nibble db[7:4] write, 50-cycle gap (1 us), low nibble db[3:0] write, 2000-cycle wait (40 us), done=1 for exactly one cycle, busy=0 in the same cycle.
REQ-013 lcd_rs SHALL equal captured bit9 for both nibbles; lcd_rw SHALL be 0 at all times; sf_ce0 SHALL be 1 at all times.
REQ-014 Main FSM states: PWR_WAIT, INIT_NIB, INIT_WAIT, IDLE, CAPTURE, HI_NIB, GAP, LO_NIB, CMD_WAIT, DONE; DONE -> IDLE unconditionally.
REQ-015 Latency start-sample edge to done pulse SHALL be 1 + 15 + 50 + 15 + 2000 = 2081 cycles.
REQ-016 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-017 A single 20-bit down-counter SHALL provide all waits; it is loaded with N-1 at state entry, and the state exits when it reads 0.
REQ-018 done SHALL never be high for two consecutive cycles.
REQ-019 Commands needing more than 40 us (clear/home, 1.64 ms) are the sequencer's responsibility; the transmitter's done timing is command-independent.

Reset
REQ-020 On reset: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, sf_ce0=1, done=0, busy=0, ready=0, counter=0, state=PWR_WAIT.
REQ-021 Reset mid-transfer SHALL drop lcd_e immediately and restart the full power-on init; no done is produced for the aborted instruction.

Structure
REQ-022 A shared package SHALL hold the timing constants (T_SETUP=2, T_E_HIGH=12, T_HOLD=1, T_GAP=50, T_CMD=2000, T_PWR=750000, T_INIT1=205000, T_INIT2=5000) and the state encodings.
REQ-023 One sub-module lcd_e_pulse_gen (states SETUP/EHIGH/HOLD, inputs go/nibble/rs, output nib_done) SHALL generate every nibble write and be shared by init and transfer paths.

Verification
REQ-024 Reset release, no start -> lcd_e pulses exactly 4 times, nibbles 0x3, 0x3, 0x3, 0x2; first E rise at cycle 750002; ready rises after the final 2000-cycle wait.
REQ-025 After ready, start=1 for one cycle, db_in=0x028 valid the next cycle -> lcd_d=0x2 then 0x8 on E highs, rs=0, rw=0, E high 12 cycles each, done 2081 cycles after the start edge.
REQ-026 Data write db_in=0x248 ('H', RS=1) -> nibbles 0x4, 0x8 with lcd_rs=1 throughout both setup/E/hold windows.
REQ-027 start pulsed during init and again 100 cycles into a transfer -> both ignored; only one done is produced per accepted start.
REQ-028 reset asserted during the LO_NIB E-high phase -> lcd_e=0 the same cycle, no done, init sequence restarts from PWR_WAIT.
REQ-029 Back-to-back: start issued in the cycle after done -> accepted; 16 consecutive writes produce 16 single-cycle done pulses spaced 2082 cycles apart.

Source files
------------

// File: rtl/lcd_nibble_tx_pkg.sv
// Shared timing constants, state encodings and helpers for the LCD 4-bit transmitter.
package lcd_nibble_tx_pkg;

  localparam int unsigned CNT_W    = 20;
  localparam int unsigned T_SETUP  = 2;
  localparam int unsigned T_E_HIGH = 12;
  localparam int unsigned T_HOLD   = 1;
  localparam int unsigned T_GAP    = 50;
  localparam int unsigned T_CMD    = 2000;
  localparam int unsigned T_PWR    = 750000;
  localparam int unsigned T_INIT1  = 205000;
  localparam int unsigned T_INIT2  = 5000;

  typedef enum logic [3:0] {
    PWR_WAIT  = 4'd0,
    INIT_NIB  = 4'd1,
    INIT_WAIT = 4'd2,
    IDLE      = 4'd3,
    CAPTURE   = 4'd4,
    HI_NIB    = 4'd5,
    GAP       = 4'd6,
    LO_NIB    = 4'd7,
    CMD_WAIT  = 4'd8,
    DONE      = 4'd9
  } main_state_t;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    SETUP  = 2'd1,
    EHIGH  = 2'd2,
    HOLD   = 2'd3
  } pulse_state_t;

  // Init nibble number 0..3: three 0x3 wake-ups, then 0x2 selects 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] step);
    return (step == 2'd3) ? 4'h2 : 4'h3;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx_pulse.sv
// One nibble write on the LCD bus: setup with E low, E high, then a data hold cycle.
module lcd_e_pulse_gen
  import lcd_nibble_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [3:0] nibble,
  input  logic       rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       lcd_rs,
  output logic       nib_done
);

  pulse_state_t state, next_state;
  logic [3:0]   cnt, cnt_next;
  logic         load;

  always_comb begin
    next_state = state;
    cnt_next   = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
    load       = 1'b0;
    case (state)
      P_IDLE: if (go) begin
        next_state = SETUP;
        cnt_next   = 4'(T_SETUP - 1);
        load       = 1'b1;
      end
      SETUP: if (cnt == 4'd0) begin
        next_state = EHIGH;
        cnt_next   = 4'(T_E_HIGH - 1);
      end
      EHIGH: if (cnt == 4'd0) begin
        next_state = HOLD;
        cnt_next   = 4'(T_HOLD - 1);
      end
      HOLD: if (cnt == 4'd0) next_state = P_IDLE;
      default: next_state = P_IDLE;
    endcase
  end

  // nib_done marks the final hold cycle so the caller leaves its state on the same edge.
  assign nib_done = (state == HOLD) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= P_IDLE;
      cnt    <= 4'd0;
      lcd_e  <= 1'b0;
      lcd_d  <= 4'h0;
      lcd_rs <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      lcd_e <= (next_state == EHIGH);
      if (load) begin
        lcd_d  <= nibble;
        lcd_rs <= rs;
      end
    end
  end

endmodule

// File: rtl/lcd_nibble_tx.sv
// LCD 4-bit instruction transmitter: power-on init, then high/low nibble writes per instruction.
module lcd_nibble_tx
  import lcd_nibble_tx_pkg::*;
#(
  parameter int unsigned PWR_CYCLES   = T_PWR,
  parameter int unsigned INIT1_CYCLES = T_INIT1,
  parameter int unsigned INIT2_CYCLES = T_INIT2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] db_in,
  output logic       done,
  output logic       ready,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] lcd_d,
  output logic       sf_ce0
);

  main_state_t      state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next, init_load;
  logic             armed, armed_next;
  logic [1:0]       step, step_next;
  logic [3:0]       lo_q;
  logic             rs_q, capture;
  logic             go, go_rs, nib_done;
  logic [3:0]       go_nibble;
  logic             rw_unused;

  assign rw_unused = db_in[8];
  assign lcd_rw    = 1'b0;
  assign sf_ce0    = 1'b1;

  always_comb begin
    case (step)
      2'd0:    init_load = CNT_W'(INIT1_CYCLES - 1);
      2'd1:    init_load = CNT_W'(INIT2_CYCLES - 1);
      default: init_load = CNT_W'(T_CMD - 1);
    endcase
  end

  always_comb begin
    next_state = state;
    cnt_next   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    armed_next = armed;
    step_next  = step;
    go         = 1'b0;
    go_nibble  = 4'h0;
    go_rs      = 1'b0;
    capture    = 1'b0;
    case (state)
      // Reset leaves the counter at 0, so the first cycle out of reset loads the power-on wait.
      PWR_WAIT: begin
        if (!armed) begin
          armed_next = 1'b1;
          cnt_next   = CNT_W'(PWR_CYCLES - 2);
        end else if (cnt == '0) begin
          next_state = INIT_NIB;
          go         = 1'b1;
          go_nibble  = init_nibble(2'd0);
        end
      end
      INIT_NIB: if (nib_done) begin
        next_state = INIT_WAIT;
        cnt_next   = init_load;
      end
      INIT_WAIT: if (cnt == '0) begin
        if (step == 2'd3) begin
          next_state = IDLE;
        end else begin
          next_state = INIT_NIB;
          go         = 1'b1;
          go_nibble  = init_nibble(step + 2'd1);
          step_next  = step + 2'd1;
        end
      end
      IDLE: if (start) next_state = CAPTURE;
      // db_in becomes valid one cycle after start, so the high nibble comes straight off the bus.
      CAPTURE: begin
        next_state = HI_NIB;
        capture    = 1'b1;
        go         = 1'b1;
        go_nibble  = db_in[7:4];
        go_rs      = db_in[9];
      end
      HI_NIB: if (nib_done) begin
        next_state = GAP;
        cnt_next   = CNT_W'(T_GAP - 1);
      end
      GAP: if (cnt == '0) begin
        next_state = LO_NIB;
        go         = 1'b1;
        go_nibble  = lo_q;
        go_rs      = rs_q;
      end
      // The DONE cycle is the last cycle of the 40 us execution wait.
      LO_NIB: if (nib_done) begin
        next_state = CMD_WAIT;
        cnt_next   = CNT_W'(T_CMD - 2);
      end
      CMD_WAIT: if (cnt == '0) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = PWR_WAIT;
    endcase
  end

  // done lags the DONE state by one cycle, so the sequencer's reply to done lands in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PWR_WAIT;
      cnt   <= '0;
      armed <= 1'b0;
      step  <= 2'd0;
      lo_q  <= 4'h0;
      rs_q  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      armed <= armed_next;
      step  <= step_next;
      if (capture) begin
        lo_q <= db_in[3:0];
        rs_q <= db_in[9];
      end
      done  <= (state == DONE);
      busy  <= (next_state inside {CAPTURE, HI_NIB, GAP, LO_NIB, CMD_WAIT, DONE});
      ready <= !(next_state inside {PWR_WAIT, INIT_NIB, INIT_WAIT});
    end
  end

  lcd_e_pulse_gen u_pulse (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .nibble   (go_nibble),
    .rs       (go_rs),
    .lcd_e    (lcd_e),
    .lcd_d    (lcd_d),
    .lcd_rs   (lcd_rs),
    .nib_done (nib_done)
  );

endmodule
